// File: rtl/skinny_round_ctrl.sv
// skinny_round_ctrl -- round sequencer for the iterative SKINNY-128 datapath.
// Issues a one-cycle load strobe, then NR round enables carrying the 6-bit
// LFSR round constant and the round index. The finished block is presented
// with a valid/ready handshake.
// Optional build macro: SKINNY_ROUND_STALL_EN adds a 'stall' input that
// freezes the sequencer in ROUND, for example while a masked S-box waits
// for fresh randomness.
module skinny_round_ctrl #(
  parameter int NR = 40,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          out_ready,
`ifdef SKINNY_ROUND_STALL_EN
  input  logic          stall,
`endif
  output logic          load,
  output logic          round_en,
  output logic [5:0]    rc,
  output logic [CW-1:0] rnd_cnt,
  output logic          last_round,
  output logic          out_valid,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, OUT} state_t;

  localparam logic [CW-1:0] LAST = CW'(NR - 1);

  state_t state;
  logic   load_q;
  logic   round_q;
  logic   valid_q;
  logic   busy_q;
  logic   hold;

  // SKINNY 6-bit round-constant LFSR: shift left, feedback rc5 ^ rc4 ^ 1
  function automatic logic [5:0] rc_next(input logic [5:0] r);
    return {r[4:0], r[5] ^ r[4] ^ 1'b1};
  endfunction

`ifdef SKINNY_ROUND_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  // Sequencer FSM; strobes are registered alongside the state they decode
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rc      <= 6'h00;
      rnd_cnt <= '0;
      load_q  <= 1'b0;
      round_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            rc      <= 6'h01;
            rnd_cnt <= '0;
            load_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          state   <= ROUND;
          load_q  <= 1'b0;
          round_q <= 1'b1;
        end
        ROUND: begin
          if (!hold) begin
            if (rnd_cnt == LAST) begin
              // rc and rnd_cnt keep their final-round values from here on
              state   <= OUT;
              round_q <= 1'b0;
              valid_q <= 1'b1;
            end else begin
              rc      <= rc_next(rc);
              rnd_cnt <= rnd_cnt + CW'(1);
            end
          end
        end
        OUT: begin
          // start arriving together with out_ready is deliberately dropped
          if (out_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Stall only gates the round enable; everything else comes straight from registers
  always_comb begin
    load       = load_q;
    round_en   = round_q & ~hold;
    last_round = round_q & ~hold & (rnd_cnt == LAST);
    out_valid  = valid_q;
    busy       = busy_q;
  end

endmodule

// File: tb/tb_skinny_round_ctrl.sv
// Testbench for skinny_round_ctrl (NR=40). It compares the DUT against a
// block-position model every cycle and adds directed latency and boundary
// checks. Define SKINNY_ROUND_STALL_EN for both bench and RTL to cover stall.
module tb_skinny_round_ctrl;
  localparam int NR = 40;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          out_ready;
  logic          load;
  logic          round_en;
  logic [5:0]    rc;
  logic [CW-1:0] rnd_cnt;
  logic          last_round;
  logic          out_valid;
  logic          busy;
  logic          stall_v;
`ifdef SKINNY_ROUND_STALL_EN
  logic          stall;
  assign stall_v = stall;
`else
  assign stall_v = 1'b0;
`endif

  always #5 clk = ~clk;

  skinny_round_ctrl #(.NR(NR), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .out_ready  (out_ready),
`ifdef SKINNY_ROUND_STALL_EN
    .stall      (stall),
`endif
    .load       (load),
    .round_en   (round_en),
    .rc         (rc),
    .rnd_cnt    (rnd_cnt),
    .last_round (last_round),
    .out_valid  (out_valid),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Round constants from the LFSR recurrence, starting at 01
  logic [5:0] rc_tab [NR];

  // Abstract model: pos = -1 idle, 0 load, 1..NR round pos-1, NR+1 result pending
  int         pos = -1;
  logic [5:0] m_rc = 6'h00;
  int         m_cnt = 0;
  bit         model_on = 1'b0;
  int         ecnt = 0;

  always @(posedge clk) begin
    ecnt++;
    if (rst) begin
      pos = -1; m_rc = 6'h00; m_cnt = 0;
    end else if (pos == -1) begin
      if (start) begin pos = 0; m_rc = rc_tab[0]; m_cnt = 0; end
    end else if (pos == 0) begin
      pos = 1;
    end else if (pos <= NR) begin
      if (!stall_v) pos = (pos == NR) ? NR + 1 : pos + 1;
    end else if (out_ready) begin
      pos = -1;
    end
    if (pos >= 1 && pos <= NR) begin
      m_rc = rc_tab[pos-1];
      m_cnt = pos - 1;
    end
  end

  // Event log used by the directed latency checks
  int ld_cyc = 0, ld_prev = 0, re0_cyc = 0, lr_cyc = 0, ov_cyc = 0;
  int n_load = 0, n_last = 0;
  bit ov_prev = 1'b0;

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (model_on) begin
      chk("load",       load,       (pos == 0));
      chk("round_en",   round_en,   (pos >= 1 && pos <= NR && !stall_v));
      chk("last_round", last_round, (pos == NR && !stall_v));
      chk("out_valid",  out_valid,  (pos == NR + 1));
      chk("busy",       busy,       (pos != -1));
      chk("rc",         rc,         m_rc);
      chk("rnd_cnt",    rnd_cnt,    m_cnt);
      if (load) begin ld_prev = ld_cyc; ld_cyc = ecnt; n_load++; end
      if (round_en && rnd_cnt == 0) re0_cyc = ecnt;
      if (last_round) begin lr_cyc = ecnt; n_last++; end
      if (out_valid && !ov_prev) ov_cyc = ecnt;
      ov_prev = out_valid;
    end
  end

  task automatic tick;
    @(posedge clk); #2;
  endtask

  task automatic settle;
    @(negedge clk); #1;
  endtask

  task automatic wait_ov(input string tag);
    int n = 0;
    while (!out_valid && n < NR + 20) begin tick; n++; end
    chk({tag, "_ov_reached"}, out_valid, 1);
  endtask

  task automatic wait_round(input string tag, input int r);
    int n = 0;
    while (!(round_en && rnd_cnt == r) && n < NR + 20) begin tick; n++; end
    chk({tag, "_round_reached"}, rnd_cnt, r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int s, nl, nlast;
    logic [5:0] r;
    logic [5:0] pin [12];
    rc_tab[0] = 6'h01;
    for (int i = 1; i < NR; i++) begin
      r = rc_tab[i-1];
      rc_tab[i] = {r[4:0], ~(r[5] ^ r[4])};
    end
    pin = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B,
            6'h37, 6'h2F, 6'h1E, 6'h3C};
    for (int i = 0; i < 12; i++) chk("rc_table_pin", rc_tab[i], pin[i]);

    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
`ifdef SKINNY_ROUND_STALL_EN
    stall = 1'b0;
`endif
    tick;
    model_on = 1'b1;
    tick;
    chk("reset_busy", busy, 0);
    chk("reset_rc", rc, 6'h00);
    chk("reset_cnt", rnd_cnt, 0);
    rst = 1'b0;
    tick;

    // Block 1: latency, then out_ready held low in OUT
    nlast = n_last;
    s = ecnt; start = 1'b1; tick; start = 1'b0;
    wait_ov("b1");
    settle;
    chk("b1_load_cycle", ld_cyc - s, 1);
    chk("b1_first_round_cycle", re0_cyc - s, 2);
    chk("b1_last_round_cycle", lr_cyc - s, NR + 1);
    chk("b1_last_round_count", n_last - nlast, 1);
    chk("b1_ov_cycle", ov_cyc - s, NR + 2);
    repeat (5) begin
      tick;
      chk("b1_ov_hold", out_valid, 1);
      chk("b1_busy_hold", busy, 1);
    end
    out_ready = 1'b1;
    tick;
    chk("b1_ov_drop", out_valid, 0);
    chk("b1_busy_drop", busy, 0);
    tick;

    // Block 2: start pulses while busy are ignored
    nl = n_load;
    start = 1'b1; tick; start = 1'b0;
    wait_round("b2r3", 3);
    start = 1'b1; tick; start = 1'b0;
    wait_round("b2r20", 20);
    start = 1'b1; tick; start = 1'b0;
    wait_ov("b2");
    start = 1'b1; tick; start = 1'b0;
    repeat (3) tick;
    chk("b2_single_load", n_load - nl, 1);
    chk("b2_idle_after", busy, 0);

    // Block 3: reset at round 17, then a clean block
    start = 1'b1; tick; start = 1'b0;
    wait_round("b3r17", 17);
    rst = 1'b1; tick; rst = 1'b0;
    chk("b3_rst_round_en", round_en, 0);
    chk("b3_rst_busy", busy, 0);
    chk("b3_rst_ov", out_valid, 0);
    chk("b3_rst_rc", rc, 6'h00);
    chk("b3_rst_cnt", rnd_cnt, 0);
    tick;
    s = ecnt; start = 1'b1; tick; start = 1'b0;
    tick;
    chk("b3_first_rc", rc, 6'h01);
    wait_ov("b3");
    settle;
    chk("b3_ov_cycle", ov_cyc - s, NR + 2);
    tick; tick;

    // Blocks 4 and 5: back to back, start held and out_ready tied high
    nl = n_load;
    start = 1'b1;
    for (int n = 0; n < 2 * NR + 20 && n_load < nl + 2; n++) tick;
    start = 1'b0;
    chk("b45_two_loads", n_load - nl, 2);
    chk("b45_spacing", ld_cyc - ld_prev, NR + 3);
    chk("b45_after_ov", ld_cyc - ov_cyc, 2);
    wait_ov("b5");
    tick; tick;

`ifdef SKINNY_ROUND_STALL_EN
    // Block 6: 3-cycle stall in round 5
    s = ecnt; start = 1'b1; tick; start = 1'b0;
    wait_round("b6r5", 5);
    stall = 1'b1;
    repeat (3) begin
      #1;
      chk("b6_stall_en", round_en, 0);
      chk("b6_stall_rc", rc, 6'h3E);
      chk("b6_stall_cnt", rnd_cnt, 5);
      tick;
    end
    stall = 1'b0;
    wait_ov("b6");
    settle;
    chk("b6_ov_cycle", ov_cyc - s, NR + 5);
    tick; tick;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/skinny_round_ctrl.md
Name: skinny_round_ctrl

Overview:
- Round sequencer for the iterative SKINNY-128 round datapath (SubCells, AddConstants, AddRoundTweakey, ShiftRows, MixColumns).
- Accepts a start request and generates the one-cycle load strobe, then NR per-round enables with the 6-bit LFSR round constant and the round index.
- Presents the result with a valid/ready handshake.
- Sits between the mode controller and the round/tweakey-schedule datapath.

Parameters:
- NR, 40, number of rounds (40 / 48 / 56 for TK1 / TK2 / TK3); legal 1..63.
- CW, 6, width of the round counter; must satisfy 2^CW > NR.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin one block; sampled only in IDLE.
- out_ready  input  1  consumer accepts the result.
- load  output  1  datapath state/tweakey registers capture new input this cycle.
- round_en  output  1  datapath registers take the round-function output this cycle.
- rc  output  6  round constant for the current round; drives AddConstants.
- rnd_cnt  output  CW  index of the current round, 0..NR-1.
- last_round  output  1  high when round_en=1 and rnd_cnt=NR-1.
- out_valid  output  1  result in datapath register is valid.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst=1 at a clk edge, in any state including mid-block): state=IDLE, rc=6'h00, rnd_cnt=0. All 1-bit outputs are 0. No partial result is ever flagged valid.
- FSM states: IDLE, LOAD, ROUND, OUT.
  - IDLE: when start=1, go to LOAD; otherwise stay.
  - LOAD: load=1 for exactly one cycle. rc is preset to 6'h01 and rnd_cnt to 0. Next state is ROUND.
  - ROUND: round_en=1 every cycle. At each edge, rc advances as {rc[4:0], rc[5]^rc[4]^1'b1} and rnd_cnt increments. When rnd_cnt=NR-1, last_round=1 and the next state is OUT; rc and rnd_cnt then hold their final values.
  - OUT: out_valid=1 and held until out_ready=1; out_ready=1 in OUT returns the FSM to IDLE on that edge.
- Outputs are decoded from registered state (Moore); no combinational path from start or out_ready to any output.
- Round constant sequence from round 0: 01, 03, 07, 0F, 1F, 3E, 3D, 3B, 37, 2F, 1E, 3C, …
- Latency with start sampled at edge 0 and out_ready held high:
  - load is high in cycle 1.
  - round_en is high in cycles 2..NR+1.
  - out_valid is high in cycle NR+2.
  - busy is low again from cycle NR+3, and the next start is accepted at that edge.
- start while busy is ignored, not queued; this includes start together with out_ready in OUT.
- out_ready outside OUT has no effect.
- load, round_en and out_valid are mutually exclusive.
- When round_en=0, rc and rnd_cnt are don't-care for the datapath but must still follow the rules above.

Optional Feature:
- Macro SKINNY_ROUND_STALL_EN adds input port stall (1 bit).
- With the macro defined:
  - In ROUND, stall=1 forces round_en=0 and freezes rc, rnd_cnt and state.
  - last_round is asserted only on the non-stalled cycle of round NR-1.
  - stall has no effect in the other states.
  - Purpose: wait for fresh randomness in the masked S-box.
- Without the macro: the port does not exist and rounds run back-to-back.

Test Plan:
- Reset, then start pulse (NR=40) -> load high in exactly cycle 1. round_en high in cycles 2..41. rc in the first eight rounds = 01,03,07,0F,1F,3E,3D,3B. last_round only in cycle 41 with rnd_cnt=39. out_valid in cycle 42.
- out_ready held low for 5 cycles in OUT -> out_valid stays high for all 5 cycles, with busy=1. Raising out_ready -> IDLE on the next edge; out_valid=0 and busy=0.
- start pulsed at rounds 3 and 20 and in OUT alongside out_ready -> no effect; exactly one block is processed and rnd_cnt is monotonic.
- rst asserted at round 17 -> next cycle: all outputs 0, rc=00, rnd_cnt=0. A new start gives the full sequence from rc=01 with no early out_valid.
- Two back-to-back blocks with out_ready tied high -> second start accepted one cycle after out_valid. Second block uses the identical rc sequence and the same 43-cycle start-to-done spacing.
- With SKINNY_ROUND_STALL_EN, stall=1 for 3 cycles at round 5 -> round_en low for those 3 cycles, rc held at 3E and rnd_cnt held at 5. out_valid is delayed to cycle 45.
